// File: rtl/check_3_times.sv
// check_3_times: synchronized (optionally debounced) push-button press counter, count modulo 4.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous reset, active-high
//   btn       - raw asynchronous button level
//   count_3   - registered press count 0..3
//   reached_3 - registered, high exactly while count_3 == 3
//   press     - registered one-clk pulse per accepted press
// Build option CHECK3_DEBOUNCE_EN inserts a debounce filter ahead of the level register.
module check_3_times #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP            = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [1:0] count_3,
    output logic       reached_3,
    output logic       press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   level;
    logic                   prev_q;
    logic                   rise;
    logic [1:0]             count_nxt;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef CHECK3_DEBOUNCE_EN
    localparam int WARM = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] db_cnt;
    logic          level_q;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= '0;
            level_q <= 1'b0;
        end else if (sync_lvl == level_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync_lvl;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = level_q;
`else
    localparam int WARM = SYNC_STAGES;

    assign level = sync_lvl;
`endif

    localparam int WW = $clog2(WARM + 1);

    // Reset clears the synchronizer, so for WARM cycles afterwards the
    // level path does not yet reflect the real button. prev is held at 1
    // until then, so a button held across reset release is not a press.
    logic [WW-1:0] warm_q;
    logic          armed;

    assign armed = (warm_q == WW'(WARM));
    assign rise  = level & ~prev_q;

    always_comb begin
        count_nxt = count_3 + 2'd1;
        if (count_3 == 2'd3) begin
            count_nxt = (WRAP != 0) ? 2'd0 : 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b1;
            warm_q    <= '0;
            count_3   <= 2'd0;
            reached_3 <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            if (!armed) begin
                warm_q <= warm_q + 1'b1;
            end
            prev_q <= armed ? level : 1'b1;
            press  <= rise;
            if (rise) begin
                count_3   <= count_nxt;
                reached_3 <= (count_nxt == 2'd3);
            end
        end
    end

endmodule

// File: tb/tb_check_3_times.sv
// tb_check_3_times: scoreboard bench for check_3_times.
// Stimulus pushes expected count/reached per press; a monitor checks each press pulse.
module tb_check_3_times;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int WRAP = 1;
`ifdef CHECK3_DEBOUNCE_EN
    localparam int LAT  = SYNC + DEB;
`else
    localparam int LAT  = SYNC;
`endif

    typedef struct packed {
        logic [1:0] cnt;
        logic       rch;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [1:0] count_3;
    logic       reached_3;
    logic       press;

    exp_t       exp_q[$];
    int         exp_cnt = 0;
    int         pushes  = 0;
    int         pulses  = 0;
    int         errors  = 0;
    int         checks  = 0;

    check_3_times #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .WRAP           (WRAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .count_3  (count_3),
        .reached_3(reached_3),
        .press    (press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_press();
        if (exp_cnt != 3) exp_cnt++;
        else if (WRAP != 0) exp_cnt = 0;
        exp_q.push_back({2'(exp_cnt), exp_cnt == 3});
        pushes++;
    endtask

    // Called on a negedge; holds btn high for hi clks, then low for lo clks.
    task automatic press_btn(input int hi, input int lo);
        push_press();
        btn = 1'b1;
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (press) begin
            exp_t e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_press: count_3=%0d reached_3=%0d",
                         count_3, reached_3);
            end else begin
                e = exp_q.pop_front();
                if (count_3 != e.cnt || reached_3 != e.rch) begin
                    errors++;
                    $display("FAIL press_value: got count=%0d reached=%0d expected count=%0d reached=%0d",
                             count_3, reached_3, e.cnt, e.rch);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", int'(count_3), 0);
        chk("reset_reached", int'(reached_3), 0);
        chk("reset_press", int'(press), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        repeat (3) press_btn(8, 8);
        chk("reached_after_3", int'(reached_3), 1);

        repeat (3) press_btn(8, 8);
        chk("reached_after_wrap", int'(reached_3), 0);

        // Reset while the button is held high: no count on release.
        btn = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("midreset_count", int'(count_3), 0);
        chk("midreset_reached", int'(reached_3), 0);

        repeat (3) press_btn(8, 8);
        chk("after_reset_count", int'(count_3), 3);

        // Latency: btn rises before edge k, press at edge k+LAT.
        push_press();
        btn = 1'b1;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("latency_early", int'(press), 0);
        @(posedge clk);
        #1;
        chk("latency_press", int'(press), 1);
        chk("latency_count", int'(count_3), exp_cnt);
        @(negedge clk);
        repeat (6) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);

`ifdef CHECK3_DEBOUNCE_EN
        btn = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_count", int'(count_3), exp_cnt);
        press_btn(DEB + 2, 12);
        chk("debounce_count", int'(count_3), exp_cnt);
`endif

        repeat (5) @(negedge clk);
        chk("pending_presses", exp_q.size(), 0);
        chk("press_pulses", pulses, pushes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
